// File: rtl/nmr_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : nmr_seq_ctrl_if
// Brief   : Host command / phase-timer signal bundle for the NMR sequencer.
// Rev     : 1.0  initial release
// ============================================================================
interface nmr_seq_ctrl_if #(
    parameter int CNT_W = 16
) ();
    logic             go;
    logic             abort;
    logic [CNT_W-1:0] echo_num;
    logic             clk_en_st1ms;
    logic             clk_en_pluse;
    logic             clk_en_scale;
    logic             clk_en_scan;
    logic             clk_en_noise;
    logic [4:0]       start;
    logic [3:0]       state_over_in;
    logic             busy;
    logic             done;
    logic             aborted;
    logic             err;
    logic [CNT_W-1:0] echo_cnt;

    // Sequencer side
    modport slave (
        input  go, abort, echo_num,
        input  clk_en_st1ms, clk_en_pluse, clk_en_scale, clk_en_scan, clk_en_noise,
        output start, state_over_in, busy, done, aborted, err, echo_cnt
    );

    // Host / timer side
    modport master (
        output go, abort, echo_num,
        output clk_en_st1ms, clk_en_pluse, clk_en_scale, clk_en_scan, clk_en_noise,
        input  start, state_over_in, busy, done, aborted, err, echo_cnt
    );
endinterface
`default_nettype wire

// File: rtl/nmr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : nmr_seq_ctrl
// Brief   : CPMG experiment sequencer issuing phase starts / early-termination
//           requests to the phase-timer subsystem and tracking its enables.
// Rev     : 1.0  initial release
// ============================================================================
module nmr_seq_ctrl #(
    parameter int ACK_TO = 16,
    parameter int CNT_W  = 16
) (
    input  wire logic     clk_sys,
    input  wire logic     rst_n,
    nmr_seq_ctrl_if.slave bus
);

    localparam int                c_TO_W    = (ACK_TO < 2) ? 1 : $clog2(ACK_TO);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(ACK_TO - 1);
    localparam logic [CNT_W-1:0]  c_CNT_ONE = CNT_W'(1);

    localparam logic [2:0] c_PH_ST1MS = 3'd0;
    localparam logic [2:0] c_PH_PLUSE = 3'd1;
    localparam logic [2:0] c_PH_SCALE = 3'd2;
    localparam logic [2:0] c_PH_SCAN  = 3'd3;
    localparam logic [2:0] c_PH_NOISE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT_HI = 3'd2,
        S_WAIT_LO = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    state_t            r_state,    w_state_nxt;
    logic [2:0]        r_phase,    w_phase_nxt,    w_phase_adv;
    logic [c_TO_W-1:0] r_to_cnt,   w_to_cnt_nxt;
    logic [CNT_W-1:0]  r_echo_num, w_echo_num_nxt;
    logic [CNT_W-1:0]  r_echo_cnt, w_echo_cnt_nxt;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [4:0]        r_start,    w_start_nxt;
    logic [3:0]        r_over,     w_over_nxt;
    logic              r_busy,     w_busy_nxt;
    logic              r_done,     w_done_nxt;
    logic              r_aborted,  w_aborted_nxt;
    logic              r_err,      w_err_nxt;

    logic [4:0]        w_en;
    logic [4:0]        w_cur_sel;
    logic              w_cur_en;
    logic              w_foreign;

    assign w_en      = {bus.clk_en_noise, bus.clk_en_scan, bus.clk_en_scale,
                        bus.clk_en_pluse, bus.clk_en_st1ms};
    assign w_cur_sel = 5'(5'b00001 << r_phase);
    assign w_cur_en  = |(w_en & w_cur_sel);
    // Any enable that does not belong to the active phase is a timer protocol fault
    assign w_foreign = (r_state != S_IDLE) && (|(w_en & ~w_cur_sel));
    assign w_cnt_inc = (r_echo_cnt == '1) ? r_echo_cnt : (r_echo_cnt + c_CNT_ONE);

    always_comb begin
        w_phase_adv = c_PH_NOISE;
        case (r_phase)
            c_PH_ST1MS: w_phase_adv = (r_echo_num == '0) ? c_PH_NOISE : c_PH_PLUSE;
            c_PH_PLUSE: w_phase_adv = c_PH_SCALE;
            c_PH_SCALE: w_phase_adv = c_PH_SCAN;
            c_PH_SCAN:  w_phase_adv = (w_cnt_inc < r_echo_num) ? c_PH_PLUSE : c_PH_NOISE;
            default:    w_phase_adv = c_PH_NOISE;
        endcase
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_phase_nxt    = r_phase;
        w_to_cnt_nxt   = r_to_cnt;
        w_echo_num_nxt = r_echo_num;
        w_echo_cnt_nxt = r_echo_cnt;
        w_over_nxt     = 4'b0000;
        w_done_nxt     = 1'b0;
        w_aborted_nxt  = 1'b0;
        w_err_nxt      = r_err | w_foreign;

        case (r_state)
            S_IDLE: begin
                if (bus.go) begin
                    w_state_nxt    = S_ISSUE;
                    w_phase_nxt    = c_PH_ST1MS;
                    w_echo_num_nxt = bus.echo_num;
                    w_echo_cnt_nxt = '0;
                    w_err_nxt      = 1'b0;
                end
            end
            S_ISSUE: begin
                w_to_cnt_nxt = '0;
                if (bus.abort) begin
                    w_state_nxt   = S_IDLE;
                    w_aborted_nxt = 1'b1;
                end else begin
                    w_state_nxt   = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (bus.abort) begin
                    w_state_nxt   = S_IDLE;
                    w_aborted_nxt = 1'b1;
                end else if (w_cur_en) begin
                    w_state_nxt   = S_WAIT_LO;
                end else if (r_to_cnt == c_TO_LAST) begin
                    w_state_nxt   = S_IDLE;
                    w_aborted_nxt = 1'b1;
                    w_err_nxt     = 1'b1;
                end else begin
                    w_to_cnt_nxt  = r_to_cnt + c_TO_W'(1);
                end
            end
            S_WAIT_LO: begin
                if (bus.abort) begin
                    // A fall seen together with abort ends the run without an over request
                    if (!w_cur_en) begin
                        w_state_nxt   = S_IDLE;
                        w_aborted_nxt = 1'b1;
                    end else begin
                        w_state_nxt   = S_DRAIN;
                        w_over_nxt    = w_cur_sel[4:1];
                    end
                end else if (!w_cur_en) begin
                    if (r_phase == c_PH_NOISE) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        if (r_phase == c_PH_SCAN) begin
                            w_echo_cnt_nxt = w_cnt_inc;
                        end
                        w_state_nxt = S_ISSUE;
                        w_phase_nxt = w_phase_adv;
                    end
                end
            end
            S_DRAIN: begin
                if (!w_cur_en) begin
                    w_state_nxt   = S_IDLE;
                    w_aborted_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_start_nxt = (w_state_nxt == S_ISSUE) ? 5'(5'b00001 << w_phase_nxt) : 5'b00000;
        w_busy_nxt  = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_phase    <= c_PH_ST1MS;
            r_to_cnt   <= '0;
            r_echo_num <= '0;
            r_echo_cnt <= '0;
            r_start    <= 5'b00000;
            r_over     <= 4'b0000;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_phase    <= w_phase_nxt;
            r_to_cnt   <= w_to_cnt_nxt;
            r_echo_num <= w_echo_num_nxt;
            r_echo_cnt <= w_echo_cnt_nxt;
            r_start    <= w_start_nxt;
            r_over     <= w_over_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_aborted  <= w_aborted_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign bus.start         = r_start;
    assign bus.state_over_in = r_over;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.aborted       = r_aborted;
    assign bus.err           = r_err;
    assign bus.echo_cnt      = r_echo_cnt;

endmodule
`default_nettype wire

// File: tb/tb_nmr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_nmr_seq_ctrl
// Brief   : Directed self-checking bench with a behavioural phase-timer.
// Rev     : 1.0  initial release
// ============================================================================
module tb_nmr_seq_ctrl;

    logic clk_sys;
    logic rst_n;

    nmr_seq_ctrl_if #(.CNT_W(16)) bus ();

    nmr_seq_ctrl #(.ACK_TO(16), .CNT_W(16)) u_dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int         checks = 0;
    int         errors = 0;
    logic [4:0] exp_q[$];
    int         rp = -1;
    int         rt = 0;
    bit         resp_on = 1'b0;
    logic [4:0] extra_en = 5'b00000;
    int         n_done = 0;
    int         n_abt = 0;
    int         n_over = 0;
    int         n_scan = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs, score starts, then drive the timer model's enables
    task automatic step();
        logic [4:0] en_vec;
        @(posedge clk_sys);
        #1;
        n_done += int'(bus.done);
        n_abt  += int'(bus.aborted);
        if (bus.state_over_in != 4'b0000) n_over++;
        if (bus.start == 5'b01000) n_scan++;
        rt++;
        if (bus.start != 5'b00000) begin
            if (exp_q.size() == 0) chk("start_unexpected", 32'(bus.start), 32'h0);
            else                   chk("start_seq", 32'(bus.start), 32'(exp_q.pop_front()));
            if (resp_on) begin
                for (int p = 0; p < 5; p++) if (bus.start[p]) begin rp = p; rt = 0; end
            end
        end
        en_vec = extra_en;
        if (rp >= 0 && rt >= 2 && rt < 7) en_vec[rp] = 1'b1;
        {bus.clk_en_noise, bus.clk_en_scan, bus.clk_en_scale,
         bus.clk_en_pluse, bus.clk_en_st1ms} = en_vec;
    endtask

    task automatic wait_end(input int budget);
        int base;
        base = n_done + n_abt;
        for (int i = 0; i < budget && (n_done + n_abt) == base; i++) step();
        chk("end_seen", 32'((n_done + n_abt) != base), 32'h1);
    endtask

    task automatic push(input logic [4:0] s);
        exp_q.push_back(s);
    endtask

    initial begin
        int d0, a0, o0, s0;
        rst_n        = 1'b0;
        bus.go       = 1'b0;
        bus.abort    = 1'b0;
        bus.echo_num = '0;
        {bus.clk_en_noise, bus.clk_en_scan, bus.clk_en_scale,
         bus.clk_en_pluse, bus.clk_en_st1ms} = 5'b00000;
        repeat (3) step();
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_start", 32'(bus.start), 32'h0);
        chk("rst_echo_cnt", 32'(bus.echo_cnt), 32'h0);
        chk("rst_err", 32'(bus.err), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        rst_n = 1'b1;
        step();

        // Normal run, two echoes
        resp_on = 1'b1;
        d0 = n_done;
        push(5'h01); push(5'h02); push(5'h04); push(5'h08);
        push(5'h02); push(5'h04); push(5'h08); push(5'h10);
        bus.echo_num = 16'd2;
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        chk("run_busy_on", 32'(bus.busy), 32'h1);
        wait_end(200);
        chk("run_done", 32'(bus.done), 32'h1);
        chk("run_busy_off", 32'(bus.busy), 32'h0);
        chk("run_echo_cnt", 32'(bus.echo_cnt), 32'd2);
        repeat (5) step();
        chk("run_done_once", 32'(n_done - d0), 32'h1);
        chk("run_q_empty", 32'(exp_q.size()), 32'h0);

        // Zero echoes, go and abort together in idle
        push(5'h01); push(5'h10);
        bus.echo_num = 16'd0;
        bus.go = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.go = 1'b0;
        bus.abort = 1'b0;
        chk("zero_busy_on", 32'(bus.busy), 32'h1);
        wait_end(100);
        chk("zero_done", 32'(bus.done), 32'h1);
        chk("zero_echo_cnt", 32'(bus.echo_cnt), 32'h0);
        chk("zero_q_empty", 32'(exp_q.size()), 32'h0);

        // Foreign enable raises err but sequence proceeds
        push(5'h01); push(5'h10);
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        extra_en = 5'b10000;
        step();
        extra_en = 5'b00000;
        step();
        chk("foreign_err", 32'(bus.err), 32'h1);
        wait_end(100);
        chk("foreign_done", 32'(bus.done), 32'h1);
        chk("foreign_q_empty", 32'(exp_q.size()), 32'h0);

        // Timeout: st1ms enable never rises
        resp_on = 1'b0;
        rp = -1;
        d0 = n_done;
        a0 = n_abt;
        push(5'h01);
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        wait_end(40);
        chk("to_err", 32'(bus.err), 32'h1);
        chk("to_aborted", 32'(n_abt - a0), 32'h1);
        chk("to_busy", 32'(bus.busy), 32'h0);
        chk("to_no_done", 32'(n_done - d0), 32'h0);
        resp_on = 1'b1;
        push(5'h01); push(5'h10);
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        chk("to_err_clear", 32'(bus.err), 32'h0);
        wait_end(100);
        chk("to_rerun_done", 32'(bus.done), 32'h1);

        // Abort while scale enable is high
        a0 = n_abt;
        o0 = n_over;
        push(5'h01); push(5'h02); push(5'h04);
        bus.echo_num = 16'd1;
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        for (int i = 0; i < 100 && !(rp == 2 && rt == 3); i++) step();
        chk("ab_reach_scale", 32'(rp == 2 && rt == 3), 32'h1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("ab_over_scale", 32'(bus.state_over_in), 32'h2);
        chk("ab_not_yet", 32'(bus.aborted), 32'h0);
        wait_end(40);
        chk("ab_aborted", 32'(n_abt - a0), 32'h1);
        chk("ab_over_once", 32'(n_over - o0), 32'h1);
        chk("ab_busy", 32'(bus.busy), 32'h0);
        repeat (10) step();
        chk("ab_q_empty", 32'(exp_q.size()), 32'h0);

        // Abort on the cycle pluse enable falls
        a0 = n_abt;
        o0 = n_over;
        push(5'h01); push(5'h02);
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        for (int i = 0; i < 100 && !(rp == 1 && rt == 7); i++) step();
        chk("fall_reach_pluse", 32'(rp == 1 && rt == 7), 32'h1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("fall_aborted", 32'(bus.aborted), 32'h1);
        repeat (10) step();
        chk("fall_no_over", 32'(n_over - o0), 32'h0);
        chk("fall_abort_once", 32'(n_abt - a0), 32'h1);
        chk("fall_q_empty", 32'(exp_q.size()), 32'h0);

        // Reset during second SCAN WAIT_LO, then a clean run
        s0 = n_scan;
        push(5'h01); push(5'h02); push(5'h04); push(5'h08);
        push(5'h02); push(5'h04); push(5'h08);
        bus.echo_num = 16'd2;
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        for (int i = 0; i < 200 && !(n_scan == s0 + 2 && rt == 4); i++) step();
        chk("rs_reach_scan", 32'(n_scan == s0 + 2 && rt == 4), 32'h1);
        chk("rs_cnt_before", 32'(bus.echo_cnt), 32'h1);
        rst_n = 1'b0;
        rp = -1;
        step();
        rst_n = 1'b1;
        chk("rs_busy", 32'(bus.busy), 32'h0);
        chk("rs_echo_cnt", 32'(bus.echo_cnt), 32'h0);
        chk("rs_start", 32'(bus.start), 32'h0);
        chk("rs_over", 32'(bus.state_over_in), 32'h0);
        chk("rs_q_empty", 32'(exp_q.size()), 32'h0);
        step();
        push(5'h01); push(5'h02); push(5'h04); push(5'h08); push(5'h10);
        bus.echo_num = 16'd1;
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        wait_end(200);
        chk("rs_rerun_done", 32'(bus.done), 32'h1);
        chk("rs_rerun_cnt", 32'(bus.echo_cnt), 32'h1);
        chk("rs_rerun_q", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
